// File: rtl/ram_pkg.sv
// Shared constants for the memory-side blocks (CPU, ROM and data RAM).
package ram_pkg;

  // Default geometry shared with the CPU and ROM blocks.
  localparam int DEF_ADDR_W     = 6;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_DEPTH      = 64;
  localparam int DEF_RD_LATENCY = 2;

  // Responder state encoding.
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/data_ram_responder_rd_pipe.sv
// Read-return pipeline: RD_LATENCY-deep shift of {valid, data} ending in the
// output flops. data_from_ram only changes on a valid beat.
module rd_pipe #(
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk_main,
  input  logic              reset,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              enable_ram_read,
  output logic [DATA_W-1:0] data_from_ram
);

  logic              last_valid;
  logic [DATA_W-1:0] last_data;

  generate
    if (RD_LATENCY == 1) begin : g_direct
      // The output flops themselves are the only stage.
      assign last_valid = rd_valid;
      assign last_data  = rd_data;
    end else begin : g_shift
      localparam int STAGES = RD_LATENCY - 1;

      logic [STAGES-1:0] vld_q;
      logic [DATA_W-1:0] dat_q [STAGES];

      // Valid bits shift toward the output; reset discards in-flight reads.
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its neighbour's pre-edge value.
      always_ff @(posedge clk_main) begin
        if (!reset) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= rd_valid;
          for (int i = 1; i < STAGES; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      // Data stages shift alongside the valid bits.
      // NOTE: no reset on data storage; the valid bits alone decide whether
      // a stage means anything, so resetting the payload would buy nothing.
      always_ff @(posedge clk_main) begin
        dat_q[0] <= rd_data;
        for (int i = 1; i < STAGES; i++) dat_q[i] <= dat_q[i-1];
      end

      assign last_valid = vld_q[STAGES-1];
      assign last_data  = dat_q[STAGES-1];
    end
  endgenerate

  // Output flops: one-cycle strobe, data held between strobes.
  always_ff @(posedge clk_main) begin
    if (!reset) begin
      enable_ram_read <= 1'b0;
      data_from_ram   <= '0;
    end else begin
      enable_ram_read <= last_valid;
      if (last_valid) data_from_ram <= last_data;
    end
  end

endmodule

// File: rtl/data_ram_responder.sv
// Data-port RAM responder: register array cleared by a hardware sweep after
// reset, then single-cycle writes and pipelined reads. A simultaneous read
// and write keeps the write, drops the read and sets a sticky error flag.
module data_ram_responder
  import ram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic              clk_main,
  input  logic              reset,
  input  logic              read_enable_to_ram,
  input  logic              write_enable_to_ram,
  input  logic [ADDR_W-1:0] address_to_ram,
  input  logic [DATA_W-1:0] data_to_ram,
  output logic [DATA_W-1:0] data_from_ram,
  output logic              enable_ram_read,
  output logic              ram_ready,
  output logic              collision_err
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0]        state_q;
  logic [ADDR_W-1:0] sweep_q;
  logic              collision_q;

  logic in_run;
  logic rd_fire;

  assign in_run  = (state_q == ST_RUN);
  // A read that collides with a write is dropped before the pipeline.
  assign rd_fire = in_run && read_enable_to_ram && !write_enable_to_ram;

  // State, sweep counter and sticky collision flag.
  always_ff @(posedge clk_main) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      collision_q <= 1'b0;
    end else if (!in_run) begin
      sweep_q <= sweep_q + 1'b1;
      if (sweep_q == ADDR_W'(DEPTH - 1)) state_q <= ST_RUN;
    end else if (read_enable_to_ram && write_enable_to_ram) begin
      collision_q <= 1'b1;
    end
  end

  // Array writes: zero fill during INIT, requested writes during RUN.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      if (!in_run)                  mem[sweep_q]        <= '0;
      else if (write_enable_to_ram) mem[address_to_ram] <= data_to_ram;
    end
  end

  rd_pipe #(
    .DATA_W     (DATA_W),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk_main        (clk_main),
    .reset           (reset),
    .rd_valid        (rd_fire),
    .rd_data         (mem[address_to_ram]),
    .enable_ram_read (enable_ram_read),
    .data_from_ram   (data_from_ram)
  );

  assign ram_ready     = in_run;
  assign collision_err = collision_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder with hand-computed expectations.
module tb_data_ram_responder;

  logic        clk_main = 1'b0;
  logic        reset;
  logic        read_enable_to_ram;
  logic        write_enable_to_ram;
  logic [5:0]  address_to_ram;
  logic [15:0] data_to_ram;
  logic [15:0] data_from_ram;
  logic        enable_ram_read;
  logic        ram_ready;
  logic        collision_err;

  int n_cmp = 0;
  int n_err = 0;

  data_ram_responder dut (
    .clk_main            (clk_main),
    .reset               (reset),
    .read_enable_to_ram  (read_enable_to_ram),
    .write_enable_to_ram (write_enable_to_ram),
    .address_to_ram      (address_to_ram),
    .data_to_ram         (data_to_ram),
    .data_from_ram       (data_from_ram),
    .enable_ram_read     (enable_ram_read),
    .ram_ready           (ram_ready),
    .collision_err       (collision_err)
  );

  always #5 clk_main = ~clk_main;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic step();
    @(posedge clk_main);
    #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [15:0] d);
    write_enable_to_ram = 1'b1;
    address_to_ram      = a;
    data_to_ram         = d;
    step();
    write_enable_to_ram = 1'b0;
  endtask

  // Single read: no strobe after the issue edge, strobe one edge later,
  // gone the edge after that.
  task automatic do_read(input string tag, input logic [5:0] a, input logic [15:0] exp);
    read_enable_to_ram = 1'b1;
    address_to_ram     = a;
    step();
    read_enable_to_ram = 1'b0;
    check({tag, "_early"}, enable_ram_read, 1'b0);
    step();
    check({tag, "_strobe"}, enable_ram_read, 1'b1);
    check({tag, "_data"}, data_from_ram, exp);
    step();
    check({tag, "_single"}, enable_ram_read, 1'b0);
  endtask

  // Count edges until ram_ready; a bounded wait.
  task automatic wait_ready(input string tag, input int exp_edges);
    int cnt;
    cnt = 0;
    while (!ram_ready && cnt < 200) begin
      step();
      cnt++;
    end
    check(tag, cnt, exp_edges);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset               = 1'b0;
    read_enable_to_ram  = 1'b0;
    write_enable_to_ram = 1'b0;
    address_to_ram      = '0;
    data_to_ram         = '0;

    // 1. Reset and clear.
    repeat (3) step();
    check("rst_ready", ram_ready, 1'b0);
    check("rst_strobe", enable_ram_read, 1'b0);
    check("rst_data", data_from_ram, 16'h0000);
    check("rst_coll", collision_err, 1'b0);
    reset = 1'b1;
    // Ready after 64 edges, i.e. visible in cycle 65.
    wait_ready("init_edges", 64);
    do_read("clr0", 6'd0, 16'h0000);
    do_read("clr37", 6'd37, 16'h0000);
    do_read("clr63", 6'd63, 16'h0000);

    // 2. Basic write then read the following cycle.
    do_write(6'h05, 16'h8006);
    do_read("wr05", 6'h05, 16'h8006);

    // 3. Back-to-back reads.
    do_write(6'd1, 16'h1111);
    do_write(6'd2, 16'h2222);
    do_write(6'd3, 16'h3333);
    read_enable_to_ram = 1'b1;
    address_to_ram     = 6'd1;
    step();
    check("b2b_none0", enable_ram_read, 1'b0);
    address_to_ram = 6'd2;
    step();
    check("b2b_s1", enable_ram_read, 1'b1);
    check("b2b_d1", data_from_ram, 16'h1111);
    address_to_ram = 6'd3;
    step();
    read_enable_to_ram = 1'b0;
    check("b2b_s2", enable_ram_read, 1'b1);
    check("b2b_d2", data_from_ram, 16'h2222);
    step();
    check("b2b_s3", enable_ram_read, 1'b1);
    check("b2b_d3", data_from_ram, 16'h3333);
    step();
    check("b2b_end", enable_ram_read, 1'b0);
    check("b2b_hold", data_from_ram, 16'h3333);

    // 4. Collision: write wins, read dropped, flag sticky.
    read_enable_to_ram  = 1'b1;
    write_enable_to_ram = 1'b1;
    address_to_ram      = 6'h10;
    data_to_ram         = 16'hFF00;
    step();
    read_enable_to_ram  = 1'b0;
    write_enable_to_ram = 1'b0;
    check("coll_set", collision_err, 1'b1);
    check("coll_nostrobe0", enable_ram_read, 1'b0);
    step();
    check("coll_nostrobe1", enable_ram_read, 1'b0);
    check("coll_sticky", collision_err, 1'b1);
    do_read("coll_rd", 6'h10, 16'hFF00);
    check("coll_sticky2", collision_err, 1'b1);

    // 5. Reset one edge after a read is issued.
    read_enable_to_ram = 1'b1;
    address_to_ram     = 6'h05;
    step();
    read_enable_to_ram = 1'b0;
    reset              = 1'b0;
    step();
    check("mid_strobe", enable_ram_read, 1'b0);
    check("mid_data", data_from_ram, 16'h0000);
    check("mid_ready", ram_ready, 1'b0);
    check("mid_coll", collision_err, 1'b0);
    reset = 1'b1;

    // 6. Requests during INIT (after word 2 has already been swept).
    repeat (10) step();
    read_enable_to_ram  = 1'b1;
    write_enable_to_ram = 1'b1;
    address_to_ram      = 6'h02;
    data_to_ram         = 16'hABCD;
    for (int i = 0; i < 3; i++) begin
      step();
      check("init_nostrobe", enable_ram_read, 1'b0);
      check("init_nocoll", collision_err, 1'b0);
    end
    read_enable_to_ram  = 1'b0;
    write_enable_to_ram = 1'b0;
    // 13 edges used, 51 remain until ready.
    wait_ready("reinit_edges", 51);
    check("reinit_coll", collision_err, 1'b0);
    do_read("post05", 6'h05, 16'h0000);
    do_read("post02", 6'h02, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
